// File: rtl/axis_bfm_pkg.sv
// Shared types and helpers for the AXI-Stream packet generator.
// Galois LFSR tap masks are right-shift form, keyed by data width.
package axis_bfm_pkg;

   typedef enum logic [1:0] {
      AXIS_MODE_INCR  = 2'd0,
      AXIS_MODE_CONST = 2'd1,
      AXIS_MODE_LFSR  = 2'd2
   } axis_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } axis_state_e;

   function automatic logic [63:0] lfsr_taps(input int w);
      logic [63:0] t;
      case (w)
         8:       t = 64'h0000_0000_0000_00B8;
         16:      t = 64'h0000_0000_0000_B400;
         32:      t = 64'h0000_0000_8020_0003;
         default: t = 64'hD800_0000_0000_0000;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/axis_lfsr.sv
// Galois LFSR whose register holds the payload that follows the current one.
// Load primes it from the seed (zero seed forced to 1); advance steps it once.
module axis_lfsr
   import axis_bfm_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              load,
   input  logic [DATA_W-1:0] seed,
   input  logic              advance,
   output logic [DATA_W-1:0] state
);

   localparam logic [63:0]       TAPS64 = lfsr_taps(DATA_W);
   localparam logic [DATA_W-1:0] TAPS   = TAPS64[DATA_W-1:0];

   function automatic logic [DATA_W-1:0] step(input logic [DATA_W-1:0] s);
      return (s >> 1) ^ (s[0] ? TAPS : '0);
   endfunction

   logic [DATA_W-1:0] state_d, state_q, seed_nz;

   always_comb begin
      seed_nz = (seed == '0) ? DATA_W'(1) : seed;
      state_d = state_q;
      if (load)
         state_d = step(seed_nz);
      else if (advance)
         state_d = step(state_q);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         state_q <= '0;
      else
         state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: length/count/gap/pattern set at start.
// Define AXIS_PKT_GEN_LFSR_EN to compile in the LFSR payload mode.
module axis_pkt_gen
   import axis_bfm_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEST_W = 4,
   parameter int LEN_W  = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  cfg_start,
   input  logic [1:0]            cfg_mode,
   input  logic [DATA_W-1:0]     cfg_seed,
   input  logic [LEN_W-1:0]      cfg_len,
   input  logic [LEN_W-1:0]      cfg_npkt,
   input  logic [7:0]            cfg_gap,
   input  logic [DEST_W-1:0]     cfg_dest,
   output logic                  m_axis_tvalid,
   output logic [DATA_W-1:0]     m_axis_tdata,
   output logic [DATA_W/8-1:0]   m_axis_tkeep,
   output logic                  m_axis_tlast,
   output logic [DEST_W-1:0]     m_axis_tdest,
   output logic [0:0]            m_axis_tuser,
   input  logic                  m_axis_tready,
   output logic                  busy,
   output logic                  done,
   output logic [LEN_W-1:0]      pkt_sent
);

   localparam int KEEP_W = DATA_W / 8;

   axis_state_e state_d, state_q;
   axis_mode_e  mode_d, mode_q, eff_mode;

   logic [LEN_W-1:0]  len_d, len_q, npkt_d, npkt_q;
   logic [LEN_W-1:0]  beat_d, beat_q, pkt_d, pkt_q;
   logic [7:0]        gap_d, gap_q, gcnt_d, gcnt_q;
   logic [DEST_W-1:0] tdest_d, tdest_q;
   logic [DATA_W-1:0] tdata_d, tdata_q;
   logic [DATA_W-1:0] start_data, nxt_data;
   logic [KEEP_W-1:0] tkeep_d, tkeep_q;
   logic tvalid_d, tvalid_q, tlast_d, tlast_q;
   logic tuser_d, tuser_q, busy_d, busy_q;
   logic done_d, done_q;
   logic fire, last_pkt;

   assign fire     = tvalid_q && m_axis_tready;
   assign last_pkt = (pkt_q + LEN_W'(1)) == npkt_q;

`ifdef AXIS_PKT_GEN_LFSR_EN
   logic [DATA_W-1:0] lfsr_state;

   assign eff_mode = (cfg_mode == 2'd0) ? AXIS_MODE_INCR :
                     (cfg_mode == 2'd2) ? AXIS_MODE_LFSR :
                                          AXIS_MODE_CONST;
   assign start_data = (eff_mode != AXIS_MODE_LFSR) ? cfg_seed :
                       (cfg_seed == '0) ? DATA_W'(1) : cfg_seed;

   axis_lfsr #(.DATA_W(DATA_W)) u_lfsr (
      .aclk    (aclk),
      .aresetn (aresetn),
      .load    (state_q == ST_IDLE && cfg_start),
      .seed    (cfg_seed),
      .advance (fire && mode_q == AXIS_MODE_LFSR),
      .state   (lfsr_state)
   );
`else
   assign eff_mode   = (cfg_mode == 2'd0) ? AXIS_MODE_INCR
                                          : AXIS_MODE_CONST;
   assign start_data = cfg_seed;
`endif

   always_comb begin
      nxt_data = tdata_q;
      unique case (mode_q)
         AXIS_MODE_INCR: nxt_data = tdata_q + DATA_W'(1);
`ifdef AXIS_PKT_GEN_LFSR_EN
         AXIS_MODE_LFSR: nxt_data = lfsr_state;
`endif
         default:        nxt_data = tdata_q;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:
            if (cfg_start)
               state_d = (cfg_npkt == '0) ? ST_DONE : ST_SEND;
         ST_SEND:
            if (fire && tlast_q) begin
               if (last_pkt)
                  state_d = ST_DONE;
               else if (gap_q != 8'd0)
                  state_d = ST_GAP;
            end
         ST_GAP:
            if (gcnt_q == 8'd1)
               state_d = ST_SEND;
         ST_DONE:
            state_d = ST_IDLE;
         default:
            state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mode_d   = mode_q;
      len_d    = len_q;
      npkt_d   = npkt_q;
      gap_d    = gap_q;
      gcnt_d   = gcnt_q;
      beat_d   = beat_q;
      pkt_d    = pkt_q;
      tdata_d  = tdata_q;
      tdest_d  = tdest_q;
      tkeep_d  = tkeep_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      tuser_d  = tuser_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      unique case (state_q)
         ST_IDLE:
            if (cfg_start) begin
               mode_d   = eff_mode;
               len_d    = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
               npkt_d   = cfg_npkt;
               gap_d    = cfg_gap;
               pkt_d    = '0;
               beat_d   = LEN_W'(1);
               tdata_d  = start_data;
               tdest_d  = cfg_dest;
               tkeep_d  = '1;
               tuser_d  = 1'b1;
               tlast_d  = cfg_len <= LEN_W'(1);
               tvalid_d = cfg_npkt != '0;
               busy_d   = cfg_npkt != '0;
               done_d   = cfg_npkt == '0;
            end
         ST_SEND:
            if (fire) begin
               tdata_d = nxt_data;
               if (!tlast_q) begin
                  beat_d  = beat_q + LEN_W'(1);
                  tlast_d = (beat_q + LEN_W'(1)) == len_q;
                  tuser_d = 1'b0;
               end else begin
                  // first beat of the next packet is staged even across a gap
                  pkt_d   = pkt_q + LEN_W'(1);
                  beat_d  = LEN_W'(1);
                  tuser_d = 1'b1;
                  tlast_d = len_q == LEN_W'(1);
                  if (last_pkt) begin
                     tvalid_d = 1'b0;
                     tuser_d  = 1'b0;
                     tlast_d  = 1'b0;
                     busy_d   = 1'b0;
                     done_d   = 1'b1;
                  end else if (gap_q != 8'd0) begin
                     tvalid_d = 1'b0;
                     gcnt_d   = gap_q;
                  end
               end
            end
         ST_GAP: begin
            gcnt_d = gcnt_q - 8'd1;
            if (gcnt_q == 8'd1)
               tvalid_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         mode_q   <= AXIS_MODE_INCR;
         len_q    <= '0;
         npkt_q   <= '0;
         gap_q    <= '0;
         gcnt_q   <= '0;
         beat_q   <= '0;
         pkt_q    <= '0;
         tdata_q  <= '0;
         tdest_q  <= '0;
         tkeep_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         len_q    <= len_d;
         npkt_q   <= npkt_d;
         gap_q    <= gap_d;
         gcnt_q   <= gcnt_d;
         beat_q   <= beat_d;
         pkt_q    <= pkt_d;
         tdata_q  <= tdata_d;
         tdest_q  <= tdest_d;
         tkeep_q  <= tkeep_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tuser_q  <= tuser_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tkeep  = tkeep_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tdest  = tdest_q;
   assign m_axis_tuser  = tuser_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pkt_sent      = pkt_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen with a beat scoreboard.
// LFSR expectations follow AXIS_PKT_GEN_LFSR_EN.
module tb_axis_pkt_gen;

   logic        clk = 1'b0;
   logic        aresetn;
   logic        cfg_start;
   logic [1:0]  cfg_mode;
   logic [31:0] cfg_seed;
   logic [15:0] cfg_len, cfg_npkt;
   logic [7:0]  cfg_gap;
   logic [3:0]  cfg_dest;
   logic        tvalid, tlast, tready, busy, done;
   logic [31:0] tdata;
   logic [3:0]  tkeep, tdest;
   logic [0:0]  tuser;
   logic [15:0] pkt_sent;

   always #5 clk = ~clk;

   axis_pkt_gen #(.DATA_W(32), .DEST_W(4), .LEN_W(16)) dut (
      .aclk          (clk),
      .aresetn       (aresetn),
      .cfg_start     (cfg_start),
      .cfg_mode      (cfg_mode),
      .cfg_seed      (cfg_seed),
      .cfg_len       (cfg_len),
      .cfg_npkt      (cfg_npkt),
      .cfg_gap       (cfg_gap),
      .cfg_dest      (cfg_dest),
      .m_axis_tvalid (tvalid),
      .m_axis_tdata  (tdata),
      .m_axis_tkeep  (tkeep),
      .m_axis_tlast  (tlast),
      .m_axis_tdest  (tdest),
      .m_axis_tuser  (tuser),
      .m_axis_tready (tready),
      .busy          (busy),
      .done          (done),
      .pkt_sent      (pkt_sent)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        user;
      logic [3:0]  dest;
   } beat_t;

   beat_t exp_q[$];

`ifdef AXIS_PKT_GEN_LFSR_EN
   localparam bit LFSR_ON = 1'b1;
`else
   localparam bit LFSR_ON = 1'b0;
`endif

   int errors = 0;
   int checks = 0;
   int cnum, hs, done_cnt, done_cyc, first_v, low_busy, busy_seen;
   logic        stall_prev = 1'b0;
   logic [31:0] sv_data;
   logic [6:0]  sv_ctl;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int mode, input logic [31:0] seed,
                           input int len, input int npkt,
                           input logic [3:0] dest);
      beat_t       e;
      logic [31:0] s;
      int          k;
      int          leff;
      leff = (len == 0) ? 1 : len;
      s = (seed == 0) ? 32'd1 : seed;
      k = 0;
      for (int p = 0; p < npkt; p++) begin
         for (int b = 1; b <= leff; b++) begin
            if (mode == 0)
               e.data = seed + 32'(k);
            else if (mode == 2 && LFSR_ON)
               e.data = s;
            else
               e.data = seed;
            e.last = (b == leff);
            e.user = (b == 1);
            e.dest = dest;
            exp_q.push_back(e);
            s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
            k++;
         end
      end
   endtask

   // observe one cycle at the falling edge, then step past the rising edge
   task automatic cyc();
      beat_t e;
      @(negedge clk);
      if (stall_prev) begin
         chk("stall_data", tdata, sv_data);
         chk("stall_ctl", {tvalid, tlast, tuser, tdest}, sv_ctl);
      end
      stall_prev = tvalid && !tready;
      sv_data = tdata;
      sv_ctl  = {tvalid, tlast, tuser, tdest};
      if (tvalid && first_v < 0) first_v = cnum;
      if (busy && !tvalid) low_busy++;
      if (busy) busy_seen++;
      if (done) begin
         done_cnt++;
         done_cyc = cnum;
         chk("done_busy", busy, 0);
      end
      if (tvalid && tready) begin
         hs++;
         chk("beat_avail", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat_data", tdata, e.data);
            chk("beat_ctl", {tlast, tuser, tdest}, {e.last, e.user, e.dest});
            chk("beat_keep", tkeep, 4'hF);
         end
      end
      @(posedge clk);
      #1;
      cnum++;
   endtask

   task automatic run(input int mode, input logic [31:0] seed,
                      input int len, input int npkt, input int gap,
                      input logic [3:0] dest, input bit toggle,
                      input int poke, input int budget);
      push_exp(mode, seed, len, npkt, dest);
      cnum = 0; hs = 0; done_cnt = 0; done_cyc = -1;
      first_v = -1; low_busy = 0; busy_seen = 0;
      cfg_mode  = 2'(mode);
      cfg_seed  = seed;
      cfg_len   = 16'(len);
      cfg_npkt  = 16'(npkt);
      cfg_gap   = 8'(gap);
      cfg_dest  = dest;
      cfg_start = 1'b1;
      tready    = !toggle;
      cyc();
      cfg_start = 1'b0;
      cfg_mode  = ~cfg_mode;
      cfg_seed  = ~seed;
      cfg_len   = 16'd7;
      cfg_npkt  = 16'd9;
      cfg_gap   = 8'd2;
      cfg_dest  = ~dest;
      while (done_cnt == 0 && cnum < budget) begin
         tready    = toggle ? (cnum % 2 == 1) : 1'b1;
         cfg_start = (cnum == poke);
         cyc();
      end
      cfg_start = 1'b0;
      tready    = 1'b1;
      chk("done_once", done_cnt, 1);
      chk("sb_empty", exp_q.size(), 0);
   endtask

   initial begin
      aresetn   = 1'b0;
      cfg_start = 1'b0;
      cfg_mode  = 2'd0;
      cfg_seed  = '0;
      cfg_len   = '0;
      cfg_npkt  = '0;
      cfg_gap   = '0;
      cfg_dest  = '0;
      tready    = 1'b1;
      #3;
      chk("reset_outs",
          {tvalid, tdata, tkeep, tlast, tdest, tuser, busy, done, pkt_sent},
          64'd0);
      @(negedge clk);
      aresetn = 1'b1;
      @(posedge clk);
      #1;

      run(0, 32'h10, 4, 2, 0, 4'h3, 1'b0, -1, 100);
      chk("s1_first_valid", first_v, 1);
      chk("s1_done_cyc", done_cyc, 9);
      chk("s1_beats", hs, 8);
      chk("s1_pkt_sent", pkt_sent, 2);
      chk("s1_no_bubble", low_busy, 0);

      run(1, 32'hA5A5_A5A5, 3, 1, 0, 4'hA, 1'b1, -1, 100);
      chk("s2_beats", hs, 3);
      chk("s2_done_cyc", done_cyc, 6);

      run(0, 32'h100, 2, 3, 3, 4'h5, 1'b0, 2, 200);
      chk("s3_gap_cycles", low_busy, 6);
      chk("s3_beats", hs, 6);
      chk("s3_done_cyc", done_cyc, 13);
      chk("s3_pkt_sent", pkt_sent, 3);
      cyc();
      cyc();
      chk("s3_idle_after", {tvalid, busy}, 2'b00);

      run(0, 32'hFFFF_FFFE, 0, 3, 0, 4'h1, 1'b0, -1, 50);
      chk("len0_done_cyc", done_cyc, 4);

      run(0, 32'h5, 4, 0, 0, 4'h2, 1'b0, -1, 20);
      chk("npkt0_done_cyc", done_cyc, 1);
      chk("npkt0_no_valid", first_v, -1);
      chk("npkt0_no_busy", busy_seen, 0);
      chk("npkt0_pkt_sent", pkt_sent, 0);

      push_exp(0, 32'h40, 5, 1, 4'h7);
      hs = 0; cnum = 0; done_cnt = 0; first_v = -1;
      cfg_mode = 2'd0; cfg_seed = 32'h40; cfg_len = 16'd5;
      cfg_npkt = 16'd1; cfg_gap = 8'd0; cfg_dest = 4'h7;
      cfg_start = 1'b1;
      cyc();
      cfg_start = 1'b0;
      for (int i = 0; i < 10 && hs < 2; i++) cyc();
      chk("rst_pre_beats", hs, 2);
      chk("rst_pre_data", tdata, 32'h42);
      aresetn = 1'b0;
      #1;
      chk("rst_async_outs",
          {tvalid, tdata, tkeep, tlast, tdest, tuser, busy, done, pkt_sent},
          64'd0);
      exp_q.delete();
      stall_prev = 1'b0;
      @(negedge clk);
      chk("rst_no_done", done, 0);
      aresetn = 1'b1;
      @(posedge clk);
      #1;
      run(0, 32'h40, 5, 1, 0, 4'h7, 1'b0, -1, 50);
      chk("rst_rerun_done_cyc", done_cyc, 6);

      run(2, 32'h0, 4, 2, 1, 4'hC, 1'b0, -1, 100);
      chk("lfsr_beats", hs, 8);
      chk("lfsr_done_cyc", done_cyc, 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
